// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the iterative multiply/divide unit.
// The optional early-termination build is selected with MULDIV_EARLY_TERM_EN.
package muldiv_pkg;

   // Widest value the negate helper handles; covers 2*WIDTH for WIDTH <= 64.
   localparam int unsigned MD_MAXW = 128;

   typedef enum logic [1:0] {
      MD_MUL  = 2'd0,
      MD_MADD = 2'd1,
      MD_MSUB = 2'd2,
      MD_DIV  = 2'd3
   } md_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_ACC
   } md_state_t;

   // Two's-complement negate; callers truncate to their own width, and the low
   // bits of a wide negate equal the negate of the low bits.
   function automatic logic [MD_MAXW-1:0] md_negate(input logic [MD_MAXW-1:0] v);
      return ~v + MD_MAXW'(1);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module muldiv_div_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Trial subtract: remainder < divisor keeps shifted < 2*divisor, so the
   // extra top bit of the difference is a clean borrow flag.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, divisor_i};
      q_o     = ~diff[WIDTH];
      rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MADD/MSUB/DIV unit for the execute stage.
// Optional macro MULDIV_EARLY_TERM_EN shortens latency for small operands.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_STEP = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   src1_in,
   input  logic [WIDTH-1:0]   src2_in,
   input  logic [2*WIDTH-1:0] hilo_in,
   input  logic               annul_in,
   output logic               stall_req,
   output logic               done,
   output logic [WIDTH-1:0]   hi_out,
   output logic [WIDTH-1:0]   lo_out,
   output logic               div_zero
);

   localparam int unsigned DW       = 2 * WIDTH;
   localparam int unsigned MUL_ITER = WIDTH / MUL_STEP;
   localparam int unsigned CW       = $clog2(WIDTH);

   md_state_t       state_q;
   md_op_t          op_q;
   logic [DW-1:0]   mcand_sh_q;   // shifted multiplicand; low WIDTH bits hold divisor in DIV
   logic [WIDTH-1:0] mplier_q;    // multiplier in MUL, dividend/quotient shifter in DIV
   logic [DW-1:0]   partial_q;    // product accumulator; low WIDTH bits are remainder in DIV
   logic [DW-1:0]   prod_q;
   logic [DW-1:0]   hilo_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, rneg_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic            done_q, dz_q;
`ifdef MULDIV_EARLY_TERM_EN
   logic            norm_q;
   logic [CW-1:0]   lz;
`endif

   md_op_t          op_in;
   logic            sign1, sign2;
   logic [WIDTH-1:0] mag1, mag2;
   logic [DW-1:0]   term, prod_next, prod_fix, acc;
   logic [WIDTH-1:0] mplier_rest;
   logic            mul_last;
   logic [WIDTH-1:0] rem_nx, quot_nx, q_fix, r_fix;
   logic            qbit;

   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (partial_q[WIDTH-1:0]),
      .bit_i     (mplier_q[WIDTH-1]),
      .divisor_i (mcand_sh_q[WIDTH-1:0]),
      .rem_o     (rem_nx),
      .q_o       (qbit)
   );

   // Operand magnitudes, one multiply/divide iteration, sign fix and accumulate.
   always_comb begin
      op_in       = md_op_t'(op);
      sign1       = is_signed & src1_in[WIDTH-1];
      sign2       = is_signed & src2_in[WIDTH-1];
      mag1        = sign1 ? WIDTH'(md_negate(MD_MAXW'(src1_in))) : src1_in;
      mag2        = sign2 ? WIDTH'(md_negate(MD_MAXW'(src2_in))) : src2_in;
      term        = mcand_sh_q * DW'(mplier_q[MUL_STEP-1:0]);
      prod_next   = partial_q + term;
      prod_fix    = neg_q ? DW'(md_negate(MD_MAXW'(prod_next))) : prod_next;
      mplier_rest = mplier_q >> MUL_STEP;
`ifdef MULDIV_EARLY_TERM_EN
      mul_last    = (cnt_q == '0) || (mplier_rest == '0);
`else
      mul_last    = (cnt_q == '0);
`endif
      quot_nx     = {mplier_q[WIDTH-2:0], qbit};
      q_fix       = neg_q ? WIDTH'(md_negate(MD_MAXW'(quot_nx))) : quot_nx;
      r_fix       = rneg_q ? WIDTH'(md_negate(MD_MAXW'(rem_nx))) : rem_nx;
      acc         = (op_q == MD_MSUB) ? (hilo_q - prod_q) : (hilo_q + prod_q);
   end

`ifdef MULDIV_EARLY_TERM_EN
   // Leading-zero count of the dividend, clamped so at least one iteration runs.
   always_comb begin
      lz = CW'(WIDTH - 1);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (mplier_q[i]) lz = CW'(WIDTH - 1 - i);
      end
   end
`endif

   // Control FSM and datapath registers; results and done are written on the
   // edge entering the done cycle so they are registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= MD_MUL;
         mcand_sh_q <= '0;
         mplier_q   <= '0;
         partial_q  <= '0;
         prod_q     <= '0;
         hilo_q     <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dz_q       <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
         norm_q     <= 1'b0;
`endif
      end else if (annul_in) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               op_q      <= op_in;
               hilo_q    <= hilo_in;
               partial_q <= '0;
               if (op_in == MD_DIV) begin
                  if (src2_in == '0) begin
                     hi_q    <= src1_in;
                     lo_q    <= '1;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_FIX;
                  end else begin
                     mcand_sh_q <= DW'(mag2);
                     mplier_q   <= mag1;
                     neg_q      <= sign1 ^ sign2;
                     rneg_q     <= sign1;
                     cnt_q      <= CW'(WIDTH - 1);
                     state_q    <= ST_DIV;
`ifdef MULDIV_EARLY_TERM_EN
                     norm_q     <= 1'b1;
`endif
                  end
               end else begin
                  mcand_sh_q <= DW'(mag1);
                  mplier_q   <= mag2;
                  neg_q      <= sign1 ^ sign2;
                  rneg_q     <= 1'b0;
                  cnt_q      <= CW'(MUL_ITER - 1);
                  state_q    <= ST_MUL;
               end
            end
            ST_MUL: begin
               partial_q  <= prod_next;
               mcand_sh_q <= mcand_sh_q << MUL_STEP;
               mplier_q   <= mplier_rest;
               cnt_q      <= cnt_q - CW'(1);
               if (mul_last) begin
                  state_q <= ST_FIX;
                  if (op_q == MD_MUL) begin
                     {hi_q, lo_q} <= prod_fix;
                     done_q       <= 1'b1;
                  end else begin
                     prod_q <= prod_fix;
                  end
               end
            end
            ST_DIV: begin
`ifdef MULDIV_EARLY_TERM_EN
               if (norm_q) begin
                  // Leading zero dividend bits give zero quotient bits and leave the
                  // remainder at 0, so shift them out in one cycle.
                  norm_q   <= 1'b0;
                  mplier_q <= mplier_q << lz;
                  cnt_q    <= CW'(WIDTH - 1) - lz;
               end else
`endif
               begin
                  partial_q <= DW'(rem_nx);
                  mplier_q  <= quot_nx;
                  cnt_q     <= cnt_q - CW'(1);
                  if (cnt_q == '0) begin
                     lo_q    <= q_fix;
                     hi_q    <= r_fix;
                     done_q  <= 1'b1;
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (op_q == MD_MADD || op_q == MD_MSUB) begin
                  {hi_q, lo_q} <= acc;
                  done_q       <= 1'b1;
                  state_q      <= ST_ACC;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ACC:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign stall_req = (state_q != ST_IDLE);
   assign done      = done_q;
   assign div_zero  = dz_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

endmodule
